// File: rtl/rpn_pkg.sv
// Shared RPN calculator definitions: operator codes (also used by op_controller),
// ASCII constants for operators and delimiters, and the lexer byte classes.
package rpn_pkg;

  localparam logic [3:0] OP_ADD     = 4'h0;
  localparam logic [3:0] OP_SUB     = 4'h1;
  localparam logic [3:0] OP_MUL     = 4'h2;
  localparam logic [3:0] OP_DIV     = 4'h3;
  localparam logic [3:0] OP_POP     = 4'h4;
  localparam logic [3:0] OP_UNKNOWN = 4'hf;

  localparam logic [7:0] ASCII_PLUS  = 8'h2b;
  localparam logic [7:0] ASCII_MINUS = 8'h2d;
  localparam logic [7:0] ASCII_STAR  = 8'h2a;
  localparam logic [7:0] ASCII_SLASH = 8'h2f;
  localparam logic [7:0] ASCII_DOT   = 8'h2e;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_TAB   = 8'h09;
  localparam logic [7:0] ASCII_LF    = 8'h0a;
  localparam logic [7:0] ASCII_CR    = 8'h0d;
  localparam logic [7:0] ASCII_DEL   = 8'h7f;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_NINE  = 8'h39;

  typedef enum logic [2:0] {
    CLS_DIGIT,
    CLS_OPER,
    CLS_DELIM,
    CLS_IGNORE,
    CLS_OTHER
  } byte_class_e;

endpackage

// File: rtl/rpn_char_class.sv
// Combinational byte decoder: ASCII byte -> {byte class, digit value, operator code}.
import rpn_pkg::*;

module rpn_char_class (
  input  logic [7:0]  byte_i,
  output byte_class_e cls_o,
  output logic [3:0]  digit_o,
  output logic [3:0]  op_o
);

  always_comb begin
    cls_o   = CLS_OTHER;
    op_o    = OP_UNKNOWN;
    digit_o = byte_i[3:0];
    if (byte_i >= ASCII_ZERO && byte_i <= ASCII_NINE) begin
      cls_o = CLS_DIGIT;
    end else begin
      case (byte_i)
        ASCII_PLUS:  begin cls_o = CLS_OPER; op_o = OP_ADD; end
        ASCII_MINUS: begin cls_o = CLS_OPER; op_o = OP_SUB; end
        ASCII_STAR:  begin cls_o = CLS_OPER; op_o = OP_MUL; end
        ASCII_SLASH: begin cls_o = CLS_OPER; op_o = OP_DIV; end
        ASCII_DOT:   begin cls_o = CLS_OPER; op_o = OP_POP; end
        ASCII_SPACE, ASCII_TAB, ASCII_LF, ASCII_CR: cls_o = CLS_DELIM;
        default: begin
          // Remaining control characters are line noise; anything printable is an unknown operator.
          if (byte_i < ASCII_SPACE || byte_i == ASCII_DEL) cls_o = CLS_IGNORE;
        end
      endcase
    end
  end

endmodule

// File: rtl/rpn_lexer.sv
// RPN byte tokenizer: accumulates decimal operands and emits number/operator token pulses.
// Optional macro RPN_LEXER_OVF_EN: saturating accumulator with per-operand overflow flag.
//
// state     | meaning
// S_IDLE    | between tokens, no operand in progress
// S_NUM     | accumulating operand digits
// S_OPPEND  | number just emitted, its terminating operator goes out this cycle
import rpn_pkg::*;

module rpn_lexer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic             num_valid,
  output logic [WIDTH-1:0] num,
  output logic             is_op,
  output logic [3:0]       op,
  output logic             overflow
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_NUM    = 2'd1;
  localparam logic [1:0] S_OPPEND = 2'd2;

  byte_class_e cls;
  logic [3:0]  digit;
  logic [3:0]  code;

  rpn_char_class u_char_class (
    .byte_i  (rx_data),
    .cls_o   (cls),
    .digit_o (digit),
    .op_o    (code)
  );

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [3:0]       pend_q, pend_d;
  logic             num_valid_q, num_valid_d;
  logic [WIDTH-1:0] num_q, num_d;
  logic             is_op_q, is_op_d;
  logic [3:0]       op_q, op_d;
  logic             overflow_q, overflow_d;

  logic [WIDTH-1:0] acc_next;
  logic             ovf_next;
  logic             byte_v;

`ifdef RPN_LEXER_OVF_EN
  logic [WIDTH+3:0] acc_ext;
  logic [WIDTH+3:0] mul10;
  assign acc_ext  = {4'b0000, acc_q};
  assign mul10    = (acc_ext << 3) + (acc_ext << 1) + {{WIDTH{1'b0}}, digit};
  assign ovf_next = ovf_q | (|mul10[WIDTH+3:WIDTH]);
  assign acc_next = ovf_next ? {WIDTH{1'b1}} : mul10[WIDTH-1:0];
`else
  assign ovf_next = 1'b0;
  assign acc_next = (acc_q << 3) + (acc_q << 1) + {{(WIDTH-4){1'b0}}, digit};
`endif

  assign byte_v = rx_valid && (cls != CLS_IGNORE);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    pend_d      = pend_q;
    num_valid_d = 1'b0;
    num_d       = num_q;
    is_op_d     = 1'b0;
    op_d        = op_q;
    overflow_d  = 1'b0;

    if (state_q == S_OPPEND) begin
      is_op_d = 1'b1;
      op_d    = pend_q;
      state_d = S_IDLE;
    end

    case (state_q)
      S_NUM: begin
        if (byte_v) begin
          case (cls)
            CLS_DIGIT: begin
              acc_d = acc_next;
              ovf_d = ovf_next;
            end
            CLS_DELIM: begin
              num_valid_d = 1'b1;
              num_d       = acc_q;
              overflow_d  = ovf_q;
              ovf_d       = 1'b0;
              state_d     = S_IDLE;
            end
            default: begin
              num_valid_d = 1'b1;
              num_d       = acc_q;
              overflow_d  = ovf_q;
              ovf_d       = 1'b0;
              pend_d      = code;
              state_d     = S_OPPEND;
            end
          endcase
        end
      end
      default: begin
        if (byte_v) begin
          case (cls)
            CLS_DIGIT: begin
              acc_d   = {{(WIDTH-4){1'b0}}, digit};
              ovf_d   = 1'b0;
              state_d = S_NUM;
            end
            CLS_DELIM: ;
            default: begin
              // An operator landing on a pending one queues behind it rather than colliding.
              if (state_q == S_OPPEND) begin
                pend_d  = code;
                state_d = S_OPPEND;
              end else begin
                is_op_d = 1'b1;
                op_d    = code;
              end
            end
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      pend_q      <= OP_UNKNOWN;
      num_valid_q <= 1'b0;
      num_q       <= '0;
      is_op_q     <= 1'b0;
      op_q        <= OP_UNKNOWN;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      pend_q      <= pend_d;
      num_valid_q <= num_valid_d;
      num_q       <= num_d;
      is_op_q     <= is_op_d;
      op_q        <= op_d;
      overflow_q  <= overflow_d;
    end
  end

  assign num_valid = num_valid_q;
  assign num       = num_q;
  assign is_op     = is_op_q;
  assign op        = op_q;
  assign overflow  = overflow_q;

endmodule
